// File: rtl/spatial_filter_pkg.sv
// Shared pixel/lane geometry, the packed output word layout and the signed-to-u8 clamp
// used by the spatial filter's output stage.
package spatial_filter_pkg;
  localparam int PIXEL_SIZE = 8;
  localparam int LANES      = 4;
  localparam int LANE_W     = $clog2(LANES);
  localparam int WORD_W     = PIXEL_SIZE * LANES;
  localparam int FIFO_W     = WORD_W + LANES + 1;
  localparam int CLAMP_W    = 64;

  typedef struct packed {
    logic              last;
    logic [LANES-1:0]  keep;
    logic [WORD_W-1:0] data;
  } out_word_t;

  // Saturate a signed value into an unsigned 8-bit pixel.
  function automatic logic [PIXEL_SIZE-1:0] clamp_u8(input logic signed [CLAMP_W-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > 255) begin
      return '1;
    end else begin
      return v[PIXEL_SIZE-1:0];
    end
  endfunction
endpackage

// File: rtl/axis_out_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head so the output is a plain register.
module axis_out_fifo2 #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] entry_reg [2];
  logic [1:0]   count_reg;
  logic         do_pop;
  logic         do_push;

  assign empty   = (count_reg == 2'd0);
  assign full    = (count_reg == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = entry_reg[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
      count_reg    <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            entry_reg[0] <= din;
          end else begin
            entry_reg[1] <= din;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          entry_reg[0] <= entry_reg[1];
          entry_reg[1] <= '0;
          count_reg    <= count_reg - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
          if (count_reg == 2'd1) begin
            entry_reg[0] <= din;
          end else begin
            entry_reg[0] <= entry_reg[1];
            entry_reg[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/conv_out_packer.sv
// Clamps signed convolution results to u8 pixels, packs four per 32-bit AXI-Stream word
// with TKEEP/TLAST per frame, and pulses frame_done after the TLAST word is taken.
module conv_out_packer
  import spatial_filter_pkg::*;
#(
  parameter int IN_WIDTH     = 32,
  parameter int FRAME_PIXELS = 260100
) (
  input  logic                axis_clk,
  input  logic                axis_reset_n,
  input  logic                i_s_data_valid,
  input  logic [IN_WIDTH-1:0] i_s_data,
  output logic                o_s_ready,
  output logic                o_m_data_valid,
  output logic [31:0]         o_m_data,
  output logic [3:0]          o_m_keep,
  output logic                o_m_last,
  input  logic                i_m_ready,
  output logic                o_frame_done
);
  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  logic [LANE_W-1:0]     lane_reg;
  logic [CNT_W-1:0]      pixel_cnt_reg;
  logic [WORD_W-1:0]     acc_reg;
  logic [LANES-1:0]      keep_reg;
  logic                  frame_done_reg;

  logic                  accept;
  logic                  is_last;
  logic                  word_done;
  logic [PIXEL_SIZE-1:0] pix;
  logic [WORD_W-1:0]     acc_next;
  logic [LANES-1:0]      keep_next;
  out_word_t             push_word;
  out_word_t             head_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;

  assign pix       = clamp_u8(CLAMP_W'($signed(i_s_data)));
  assign o_s_ready = !fifo_full;
  assign accept    = i_s_data_valid && o_s_ready;
  assign is_last   = (pixel_cnt_reg == LAST_PIX);
  assign word_done = accept && ((lane_reg == LANE_W'(LANES - 1)) || is_last);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign acc_next[gi*PIXEL_SIZE +: PIXEL_SIZE] =
        (lane_reg == LANE_W'(gi)) ? pix : acc_reg[gi*PIXEL_SIZE +: PIXEL_SIZE];
      assign keep_next[gi] = (lane_reg == LANE_W'(gi)) || keep_reg[gi];
    end
  endgenerate

  assign push_word.last = is_last;
  assign push_word.keep = keep_next;
  assign push_word.data = acc_next;

  axis_out_fifo2 #(.W(FIFO_W)) u_fifo (
    .clk   (axis_clk),
    .rst_n (axis_reset_n),
    .push  (word_done),
    .din   (push_word),
    .pop   (pop),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_m_data_valid = !fifo_empty;
  assign pop            = o_m_data_valid && i_m_ready;
  assign o_m_data       = head_word.data;
  assign o_m_keep       = head_word.keep;
  assign o_m_last       = head_word.last;
  assign o_frame_done   = frame_done_reg;

  always_ff @(posedge axis_clk or negedge axis_reset_n) begin
    if (!axis_reset_n) begin
      lane_reg       <= '0;
      pixel_cnt_reg  <= '0;
      acc_reg        <= '0;
      keep_reg       <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= pop && head_word.last;
      if (accept) begin
        pixel_cnt_reg <= is_last ? '0 : pixel_cnt_reg + CNT_W'(1);
        if (word_done) begin
          acc_reg  <= '0;
          keep_reg <= '0;
          lane_reg <= '0;
        end else begin
          acc_reg  <= acc_next;
          keep_reg <= keep_next;
          lane_reg <= lane_reg + LANE_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_out_packer.sv
// Drives three packers (frames of 8, 6 and 10 pixels) with shared stimulus and checks each
// against a word-queue model every cycle, plus literal expectations for key sequences.
module tb_conv_out_packer;
  localparam int NI = 3;

  function automatic int fp_of(input int k);
    return (k == 0) ? 8 : (k == 1) ? 6 : 10;
  endfunction

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          m_ready;
  logic [NI-1:0] s_ready;
  logic [NI-1:0] m_valid;
  logic [NI-1:0] m_last;
  logic [NI-1:0] fdone;
  logic [31:0]   m_data [NI];
  logic [3:0]    m_keep [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int FPV = fp_of(gi);
      conv_out_packer #(.IN_WIDTH(32), .FRAME_PIXELS(FPV)) dut (
        .axis_clk       (clk),
        .axis_reset_n   (rst_n),
        .i_s_data_valid (s_valid),
        .i_s_data       (s_data),
        .o_s_ready      (s_ready[gi]),
        .o_m_data_valid (m_valid[gi]),
        .o_m_data       (m_data[gi]),
        .o_m_keep       (m_keep[gi]),
        .o_m_last       (m_last[gi]),
        .i_m_ready      (m_ready),
        .o_frame_done   (fdone[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: up to two queued words per instance plus the pixels of the word being built.
  logic [31:0] mw_data [NI][2];
  logic [3:0]  mw_keep [NI][2];
  logic        mw_last [NI][2];
  int          mcnt    [NI];
  int          pcnt    [NI];
  int          npend   [NI];
  logic [7:0]  pend    [NI][4];
  logic        mfd     [NI];
  int          acc_cnt [NI];
  int          obs_fd  [NI];
  int          nlog    [NI];
  logic [36:0] log_w   [NI][512];

  task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h", name, k, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_clamp(input logic [31:0] raw);
    int v;
    v = raw;
    if (v < 0) return 8'h00;
    if (v > 255) return 8'hFF;
    return 8'(v);
  endfunction

  task automatic model_reset(input int k);
    mcnt[k] = 0; pcnt[k] = 0; npend[k] = 0; mfd[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    logic        pop, acc, lst;
    logic [31:0] w;
    pop = (mcnt[k] != 0) && m_ready;
    acc = s_valid && (mcnt[k] != 2);
    mfd[k] = pop && mw_last[k][0];
    if (pop) begin
      if (nlog[k] < 512) log_w[k][nlog[k]] = {mw_last[k][0], mw_keep[k][0], mw_data[k][0]};
      nlog[k]++;
      $display("txn inst=%0d data=%08h keep=%h last=%0d", k, mw_data[k][0], mw_keep[k][0], mw_last[k][0]);
      mw_data[k][0] = mw_data[k][1]; mw_keep[k][0] = mw_keep[k][1]; mw_last[k][0] = mw_last[k][1];
      mcnt[k]--;
    end
    if (acc) begin
      acc_cnt[k]++;
      pend[k][npend[k]] = ref_clamp(s_data);
      npend[k]++;
      pcnt[k]++;
      if (npend[k] == 4 || pcnt[k] == fp_of(k)) begin
        w = 32'h0;
        for (int i = 0; i < npend[k]; i++) w = w | (32'(pend[k][i]) << (8 * i));
        lst = (pcnt[k] == fp_of(k));
        mw_data[k][mcnt[k]] = w;
        mw_keep[k][mcnt[k]] = 4'((1 << npend[k]) - 1);
        mw_last[k][mcnt[k]] = lst;
        mcnt[k]++;
        npend[k] = 0;
        if (lst) pcnt[k] = 0;
      end
    end
  endtask

  // Compare process: outputs are checked mid-cycle, then the model advances for the next edge.
  initial begin
    for (int k = 0; k < NI; k++) begin
      model_reset(k); acc_cnt[k] = 0; obs_fd[k] = 0; nlog[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (fdone[k]) obs_fd[k]++;
        if (!rst_n) begin
          chk("rst_valid", k, m_valid[k], 0);
          chk("rst_data", k, m_data[k], 0);
          chk("rst_keep", k, m_keep[k], 0);
          chk("rst_last", k, m_last[k], 0);
          chk("rst_fdone", k, fdone[k], 0);
          model_reset(k);
        end else begin
          chk("valid", k, m_valid[k], mcnt[k] != 0);
          chk("s_ready", k, s_ready[k], mcnt[k] != 2);
          chk("frame_done", k, fdone[k], mfd[k]);
          if (mcnt[k] != 0) begin
            chk("data", k, m_data[k], mw_data[k][0]);
            chk("keep", k, m_keep[k], mw_keep[k][0]);
            chk("last", k, m_last[k], mw_last[k][0]);
          end
          model_step(k);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog inst=0 got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int          base [NI];
  int          abase[NI];
  int          fbase[NI];
  logic [31:0] held [NI];

  task automatic mark();
    for (int k = 0; k < NI; k++) begin
      base[k] = nlog[k]; abase[k] = acc_cnt[k]; fbase[k] = obs_fd[k];
    end
  endtask

  task automatic beat(input logic [31:0] v);
    s_valid = 1'b1; s_data = v;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("async_valid", k, m_valid[k], 0);
      chk("async_data", k, m_data[k], 0);
      chk("async_keep", k, m_keep[k], 0);
      chk("async_last", k, m_last[k], 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mark();
  endtask

  task automatic pin(input string name, input int k, input int idx, input logic [36:0] exp);
    chk(name, k, log_w[k][base[k] + idx], exp);
  endtask

  logic [31:0] clamp_in [6];
  int          done;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    mark();

    // Packing and frame wrap with partial words: pixels 1..12
    for (int i = 1; i <= 12; i++) beat(32'(i));
    idle(6);
    chk("pack_words", 0, nlog[0] - base[0], 3);
    chk("pack_words", 1, nlog[1] - base[1], 4);
    chk("pack_words", 2, nlog[2] - base[2], 3);
    pin("pack8_w0", 0, 0, {1'b0, 4'hF, 32'h04030201});
    pin("pack8_w1", 0, 1, {1'b1, 4'hF, 32'h08070605});
    pin("pack8_w2", 0, 2, {1'b0, 4'hF, 32'h0C0B0A09});
    pin("part6_w0", 1, 0, {1'b0, 4'hF, 32'h04030201});
    pin("part6_w1", 1, 1, {1'b1, 4'h3, 32'h00000605});
    pin("part6_w2", 1, 2, {1'b0, 4'hF, 32'h0A090807});
    pin("part6_w3", 1, 3, {1'b1, 4'h3, 32'h00000C0B});
    pin("pack10_w2", 2, 2, {1'b1, 4'h3, 32'h00000A09});
    chk("pack_fdone", 0, obs_fd[0] - fbase[0], 1);
    chk("pack_fdone", 1, obs_fd[1] - fbase[1], 2);
    chk("pack_fdone", 2, obs_fd[2] - fbase[2], 1);

    // Clamp boundaries
    do_reset();
    clamp_in[0] = -32'sd5; clamp_in[1] = 32'd0;   clamp_in[2] = 32'd128;
    clamp_in[3] = 32'd255; clamp_in[4] = 32'd256; clamp_in[5] = 32'h7FFFFFFF;
    for (int i = 0; i < 6; i++) beat(clamp_in[i]);
    idle(6);
    pin("clamp_w0", 1, 0, {1'b0, 4'hF, 32'hFF800000});
    pin("clamp_w1", 1, 1, {1'b1, 4'h3, 32'h0000FFFF});
    pin("clamp_w0", 0, 0, {1'b0, 4'hF, 32'hFF800000});

    // Backpressure: sink stalls for 20 cycles under continuous valid
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 32'(100 + i);
      @(posedge clk); #1;
      if (i == 9) for (int k = 0; k < NI; k++) held[k] = m_data[k];
    end
    for (int k = 0; k < NI; k++) begin
      chk("bp_s_ready", k, s_ready[k], 0);
      chk("bp_valid", k, m_valid[k], 1);
      chk("bp_stable", k, m_data[k], held[k]);
    end
    chk("bp_accepted", 0, acc_cnt[0] - abase[0], 8);
    chk("bp_accepted", 1, acc_cnt[1] - abase[1], 6);
    chk("bp_accepted", 2, acc_cnt[2] - abase[2], 8);
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle(6);
    for (int k = 0; k < NI; k++) chk("bp_drained", k, nlog[k] - base[k], 2);
    pin("bp_w0", 0, 0, {1'b0, 4'hF, 32'h67666564});
    pin("bp_w1", 0, 1, {1'b1, 4'hF, 32'h6B6A6968});
    pin("bp_w1", 1, 1, {1'b1, 4'h3, 32'h00006968});

    // Random valid/ready: five 10-pixel frames through instance 2
    do_reset();
    done = 0;
    for (int c = 0; c < 3000 && done == 0; c++) begin
      s_valid = (acc_cnt[2] - abase[2] < 50) && ($urandom_range(0, 3) != 0);
      s_data  = 32'($urandom_range(0, 511)) - 32'd128;
      m_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      if (nlog[2] - base[2] >= 15) done = 1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    idle(6);
    chk("rand_complete", 2, done, 1);
    chk("rand_words", 2, nlog[2] - base[2], 15);
    chk("rand_fdone", 2, obs_fd[2] - fbase[2], 5);
    for (int i = 0; i < 15; i++) chk("rand_tlast", 2, log_w[2][base[2] + i][36], (i % 3) == 2);

    // Reset mid-word with words still queued
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(32'h11 * (i + 1));
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) beat(32'(i));
    idle(4);
    for (int k = 0; k < NI; k++) begin
      chk("rst_mid_words", k, nlog[k] - base[k], 1);
      pin("rst_mid_w0", k, 0, {1'b0, 4'hF, 32'h04030201});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
